booth_mult_top: RTL and testbench



---
 rtl/booth_mult_top.sv | 99 +++++++++
 tb/tb_booth_mult_top.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/booth_mult_top.sv
// Sequential signed radix-4 Booth multiplier: operands latch during reset, then the product
// is accumulated over INPUT_WIDTH/2 add/shift iterations while the step counter runs to DONE.
module booth_mult_top #(
  parameter int unsigned INPUT_WIDTH  = 6,
  parameter int unsigned OUTPUT_WIDTH = 12,
  parameter int unsigned COUNTER_SIZE = 3
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic [INPUT_WIDTH-1:0]  multiplicand_in,
  input  logic [INPUT_WIDTH-1:0]  multiplier_in,
  output logic [OUTPUT_WIDTH-1:0] product_top,
  output logic [COUNTER_SIZE-1:0] counter_top
);

  localparam int unsigned Half = INPUT_WIDTH / 2;
  localparam logic [COUNTER_SIZE-1:0] Done = COUNTER_SIZE'(Half + 1);
  localparam int unsigned ShiftW = COUNTER_SIZE + 1;

  typedef enum logic [1:0] {StLoad, StIter, StHold} phase_e;

  logic [INPUT_WIDTH-1:0]  m_q, q_q;
  logic [OUTPUT_WIDTH-1:0] product_q, product_d;
  logic [COUNTER_SIZE-1:0] counter_q, counter_d;

  phase_e                  phase;
  logic [COUNTER_SIZE-1:0] iter;
  logic [ShiftW-1:0]       shamt;
  logic [INPUT_WIDTH:0]    booth_vec, booth_shift;
  logic [2:0]              triplet;
  logic [OUTPUT_WIDTH-1:0] m_ext, pp, pp_shift;

  // The counter itself is the state; the phase is just a decode of it.
  always_comb begin
    if (counter_q == '0) begin
      phase = StLoad;
    end else if (counter_q >= Done) begin
      phase = StHold;
    end else begin
      phase = StIter;
    end
  end

  always_comb begin
    iter        = counter_q - COUNTER_SIZE'(1);
    shamt       = {iter, 1'b0};
    // Appending the implicit Q[-1]=0 lets every triplet be a plain 3-bit window.
    booth_vec   = {q_q, 1'b0};
    booth_shift = booth_vec >> shamt;
    triplet     = booth_shift[2:0];
    m_ext       = {{(OUTPUT_WIDTH - INPUT_WIDTH){m_q[INPUT_WIDTH-1]}}, m_q};

    pp = '0;
    unique case (triplet)
      3'b000, 3'b111: pp = '0;
      3'b001, 3'b010: pp = m_ext;
      3'b011:         pp = m_ext << 1;
      3'b100:         pp = '0 - (m_ext << 1);
      3'b101, 3'b110: pp = '0 - m_ext;
    endcase
    pp_shift = pp << shamt;
  end

  always_comb begin
    counter_d = counter_q;
    product_d = product_q;
    unique case (phase)
      StLoad: counter_d = COUNTER_SIZE'(1);
      StIter: begin
        counter_d = counter_q + COUNTER_SIZE'(1);
        product_d = product_q + pp_shift;
      end
      StHold: begin
        counter_d = counter_q;
        product_d = product_q;
      end
      default: begin
        counter_d = counter_q;
        product_d = product_q;
      end
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      product_q <= '0;
      counter_q <= '0;
      m_q       <= multiplicand_in;
      q_q       <= multiplier_in;
    end else begin
      product_q <= product_d;
      counter_q <= counter_d;
    end
  end

  assign product_top = product_q;
  assign counter_top = counter_q;

endmodule

// File: tb/tb_booth_mult_top.sv
// Randomized scoreboard bench for booth_mult_top: each released operation queues its operands
// and product; a monitor checks reset state, step count, partial sums and the final product.
module tb_booth_mult_top;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [5:0]  mc, mp;
  logic [11:0] prod;
  logic [2:0]  cnt;

  always #5 clk = ~clk;

  booth_mult_top #(
    .INPUT_WIDTH (6),
    .OUTPUT_WIDTH(12),
    .COUNTER_SIZE(3)
  ) dut (
    .clk_in         (clk),
    .rst_in         (rst_n),
    .multiplicand_in(mc),
    .multiplier_in  (mp),
    .product_top    (prod),
    .counter_top    (cnt)
  );

  typedef struct {
    int          m;
    int          q;
    logic [11:0] exp;
  } txn_t;

  txn_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;
  logic rst_edge = 1'b0;

  always @(posedge clk) rst_edge <= rst_n;

  // Summing Booth digits 0..k-1 weighted by 4^j equals the low 2k bits of Q read as signed.
  function automatic logic [11:0] partial(int m, int q, int k);
    int lo;
    if (k == 0) return 12'd0;
    lo = q & ((1 << (2 * k)) - 1);
    if (lo >= (1 << (2 * k - 1))) lo = lo - (1 << (2 * k));
    return 12'(m * lo);
  endfunction

  task automatic check(string name, logic [11:0] act, logic [11:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%03h) expected %0d (0x%03h) at %0t",
               name, act, act, exp, exp, $time);
    end
  endtask

  // Monitor: outputs sampled at negedge reflect the preceding rising edge.
  initial begin
    txn_t cur;
    bit   active;
    int   step;
    active = 1'b0;
    step   = 0;
    cur    = '{0, 0, 12'd0};
    forever begin
      @(negedge clk);
      if (!rst_edge) begin
        check("reset_product", prod, 12'd0);
        check("reset_counter", {9'd0, cnt}, 12'd0);
        active = 1'b0;
      end else begin
        if (!active) begin
          if (sb.size() == 0) begin
            check("unexpected_run_counter", {9'd0, cnt}, 12'd0);
          end else begin
            cur    = sb.pop_front();
            active = 1'b1;
            step   = 1;
          end
        end else begin
          step = (step < 4) ? step + 1 : 4;
        end
        if (active) begin
          check("counter", {9'd0, cnt}, 12'(step));
          check("partial", prod, partial(cur.m, cur.q, step - 1));
          if (step == 4) check("result", prod, cur.exp);
        end
      end
    end
  end

  task automatic run_op(int m, int q, int abort_at);
    int  target;
    bit  hit;
    txn_t t;
    target = (abort_at != 0) ? abort_at : 4;
    rst_n  = 1'b0;
    mc     = 6'(m);
    mp     = 6'(q);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    t = '{m, q, 12'(m * q)};
    sb.push_back(t);
    hit = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      mc = 6'($urandom);
      mp = 6'($urandom);
      if (cnt == 3'(target)) begin
        hit = 1'b1;
        break;
      end
    end
    if (!hit) begin
      n_cmp++;
      n_err++;
      $display("FAIL timeout: counter %0d never reached %0d for M=%0d Q=%0d", cnt, target, m, q);
    end
    if (abort_at != 0) begin
      rst_n = 1'b0;
    end else begin
      repeat (3) begin
        @(posedge clk);
        #1;
        mc = 6'($urandom);
        mp = 6'($urandom);
      end
    end
  endtask

  initial begin
    int m, q, ab;
    rst_n = 1'b0;
    mc    = 6'd0;
    mp    = 6'd0;
    repeat (2) @(posedge clk);
    #1;

    run_op(31, 24, 0);
    run_op(-20, 31, 0);
    run_op(-23, -17, 0);
    run_op(-32, -32, 0);
    run_op(-32, 31, 0);
    run_op(0, -1, 0);
    run_op(31, 1, 0);
    run_op(17, 9, 2);
    run_op(5, -3, 0);

    for (int n = 0; n < 150; n++) begin
      m  = int'($urandom_range(0, 63)) - 32;
      q  = int'($urandom_range(0, 63)) - 32;
      ab = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 3)) : 0;
      run_op(m, q, ab);
    end

    @(posedge clk);
    #1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("queue_drained", 12'(sb.size()), 12'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
